// File: rtl/l1_l2_arbiter_if.sv
// Handshake bundle between the two L1 caches, the L1->L2 arbiter and L2.
// The arbiter uses the master modport; the environment (L1s + L2) uses slave.
interface l1_l2_arbiter_if #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned LINE_W = 512
);
    logic              read_I_L2;
    logic [ADDR_W-1:0] address_I_L2;
    logic              ready_L2_I;
    logic [LINE_W-1:0] read_data_L2_I;

    logic              read_D_L2;
    logic              write_D_L2;
    logic [ADDR_W-1:0] address_D_L2;
    logic [LINE_W-1:0] write_data_D_L2;
    logic              ready_L2_D;
    logic [LINE_W-1:0] read_data_L2_D;

    logic              read_L1_L2;
    logic              write_L1_L2;
    logic [ADDR_W-1:0] address_L1_L2;
    logic [LINE_W-1:0] write_data_L1_L2;
    logic              ready_L2_L1;
    logic [LINE_W-1:0] read_data_L2_L1;

    modport master (
        input  read_I_L2, address_I_L2,
        input  read_D_L2, write_D_L2, address_D_L2, write_data_D_L2,
        input  ready_L2_L1, read_data_L2_L1,
        output ready_L2_I, read_data_L2_I, ready_L2_D, read_data_L2_D,
        output read_L1_L2, write_L1_L2, address_L1_L2, write_data_L1_L2
    );

    modport slave (
        output read_I_L2, address_I_L2,
        output read_D_L2, write_D_L2, address_D_L2, write_data_D_L2,
        output ready_L2_L1, read_data_L2_L1,
        input  ready_L2_I, read_data_L2_I, ready_L2_D, read_data_L2_D,
        input  read_L1_L2, write_L1_L2, address_L1_L2, write_data_L1_L2
    );
endinterface

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter giving L1_I and L1_D turns on the single L2 port, one
// line transaction at a time, with registered L2 command and response paths.
module l1_l2_arbiter #(
    parameter int unsigned ADDR_W  = 26,
    parameter int unsigned LINE_W  = 512,
    parameter int unsigned TIMEOUT = 1024,
    parameter bit          FIRST_D = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    l1_l2_arbiter_if.master     bus,
    output logic                timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StBusyI,
        StBusyD,
        StResp,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;   // 1: D had the most recent grant
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata_i_q, rdata_i_d;
    logic [LINE_W-1:0] rdata_d_q, rdata_d_d;
    logic              rdy_i_q, rdy_i_d;
    logic              rdy_d_q, rdy_d_d;
    logic              terr_q, terr_d;
    logic              req_i, req_d;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_i_d = rdata_i_q;
        rdata_d_d = rdata_d_q;
        rdy_i_d   = 1'b0;
        rdy_d_d   = 1'b0;
        terr_d    = terr_q;
        req_i     = bus.read_I_L2;
        req_d     = bus.read_D_L2 | bus.write_D_L2;

        unique case (state_q)
            StIdle: begin
                // On a tie the side that did not win last time goes first.
                if (req_i && (!req_d || last_d_q)) begin
                    state_d  = StBusyI;
                    last_d_d = 1'b0;
                    cnt_d    = '0;
                    rd_d     = 1'b1;
                    wr_d     = 1'b0;
                    addr_d   = bus.address_I_L2;
                    wdata_d  = '0;
                end else if (req_d) begin
                    // A pending write-back goes first; the read gets a later grant.
                    state_d  = StBusyD;
                    last_d_d = 1'b1;
                    cnt_d    = '0;
                    rd_d     = ~bus.write_D_L2;
                    wr_d     = bus.write_D_L2;
                    addr_d   = bus.address_D_L2;
                    wdata_d  = bus.write_D_L2 ? bus.write_data_D_L2 : '0;
                end
            end
            StBusyI, StBusyD: begin
                if (bus.ready_L2_L1) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = StResp;
                    if (state_q == StBusyI) begin
                        rdata_i_d = bus.read_data_L2_L1;
                        rdy_i_d   = 1'b1;
                    end else begin
                        rdata_d_d = bus.read_data_L2_L1;
                        rdy_d_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if ((TIMEOUT != 0) && (cnt_d == TimeoutVal)) begin
                        rd_d    = 1'b0;
                        wr_d    = 1'b0;
                        terr_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StResp:  state_d = StHold;
            StHold:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_d_q  <= FIRST_D;
            cnt_q     <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_i_q <= '0;
            rdata_d_q <= '0;
            rdy_i_q   <= 1'b0;
            rdy_d_q   <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_i_q <= rdata_i_d;
            rdata_d_q <= rdata_d_d;
            rdy_i_q   <= rdy_i_d;
            rdy_d_q   <= rdy_d_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.read_L1_L2       = rd_q;
    assign bus.write_L1_L2      = wr_q;
    assign bus.address_L1_L2    = addr_q;
    assign bus.write_data_L1_L2 = wdata_q;
    assign bus.ready_L2_I       = rdy_i_q;
    assign bus.read_data_L2_I   = rdata_i_q;
    assign bus.ready_L2_D       = rdy_d_q;
    assign bus.read_data_L2_D   = rdata_d_q;
    assign timeout_err          = terr_q;

endmodule
